id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter N, default 64, datapath width of register operands and PC.
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 instr_d  in  32  decoded-stage instruction word.
REQ-005 pc_d  in  N  PC of instr_d.
REQ-006 valid_d  in  1  instr_d is a real instruction (0 = bubble).
REQ-007 ra1_d / ra2_d  out  5  regfile read addresses (combinational).
REQ-008 rd1_d / rd2_d  in  N  regfile read data for ra1_d / ra2_d.
REQ-009 we3_w, wa3_w[5], wd3_w[N]  in  writeback port, same values driven to the regfile.
REQ-010 flush  in  1  branch-taken kill of the instruction entering E.
REQ-011 en  in  1  downstream ready; 0 holds the E register.
REQ-012 stall_d  out  1  load-use stall request to fetch/decode (combinational).
REQ-013 valid_e, pc_e[N], instr_e[32], rd1_e[N], rd2_e[N], wa_e[5], memread_e, regwrite_e  out  registered E-stage fields.
REQ-014 stall_cnt  out  16  saturating count of load-use bubbles inserted.

Function
REQ-015 ra1_d SHALL be instr_d[9:5]; ra2_d SHALL be instr_d[4:0] when instr_d[28]=1 (STUR/CBZ), else instr_d[20:16].
REQ-016 Operand bypass: for each port, if ra==31 value SHALL be 0; else if we3_w=1 and wa3_w==ra and wa3_w!=31 value SHALL be wd3_w; else rd1_d/rd2_d.
REQ-017 memread SHALL be 1 iff instr_d[31:21]==LDUR opcode; regwrite SHALL be 1 for R-type, LDUR, ADDI/SUBI classes, 0 for STUR, CBZ, B.
REQ-018 Load-use hazard SHALL be: valid_e & memread_e & wa_e!=31 & valid_d & (wa_e==ra1_d | (ra2 used & wa_e==ra2_d)); ra2 used for R-type, STUR, CBZ.
REQ-019 stall_d SHALL equal hazard & ~flush & en.
REQ-020 E register update priority at posedge clk: flush > ~en > hazard > load.
REQ-021 flush=1: valid_e<=0, regwrite_e<=0, memread_e<=0; other fields don't-care; regardless of en.
REQ-022 en=0 (no flush): all E fields hold; stall_cnt holds.
REQ-023 hazard (en=1, no flush): bubble as REQ-021; stall_cnt increments, saturating at 16'hFFFF.
REQ-024 load: all E fields <= decoded/bypassed D values, valid_e<=valid_d; regwrite_e/memread_e forced 0 when valid_d=0.
REQ-025 Latency: D-to-E one cycle; a load-use pair costs exactly one bubble.
REQ-026 Bypass and hazard SHALL evaluate simultaneously; a hazard cycle still samples nothing into E.

Reset
REQ-027 reset=0 SHALL asynchronously clear valid_e, memread_e, regwrite_e, stall_cnt, pc_e, instr_e, rd1_e, rd2_e, wa_e to 0.
REQ-028 stall_d SHALL be 0 during reset and the first cycle after release (valid_e=0).
REQ-029 Reset mid-stall SHALL drop the pending bubble; no replay state kept.

Structure
REQ-030 Package legv8_pkg SHALL hold opcode constants (LDUR, STUR, CBZ, B, R-type masks), XZR=5'd31, and E-stage field struct type.
REQ-031 One sub-module hazard_unit SHALL implement REQ-018/019 combinationally; rest in id_ex_stage.

Verification
REQ-032 Reset: assert reset=0 mid-cycle -> all outputs 0 immediately, stall_cnt=0.
REQ-033 Bypass: ADD X3 reading X2 while we3_w=1, wa3_w=2, wd3_w=64'h55 -> rd1_e=64'h55 next cycle; same with wa3_w=31 -> rd1_e=rd1_d.
REQ-034 XZR: ra1_d=31 with rd1_d=64'hFFFF -> rd1_e=0.
REQ-035 Load-use: LDUR X5 then ADD X6,X5,X1 -> stall_d=1 one cycle, one bubble (valid_e=0), ADD enters E next cycle, stall_cnt=1.
REQ-036 Flush+hazard same cycle -> stall_d=0, valid_e=0, stall_cnt unchanged.
REQ-037 en=0 for 3 cycles with valid data -> E fields constant; stall_cnt saturates after 65535 forced hazards, no wrap.

Source files
------------

// File: rtl/legv8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | legv8_pkg: LEGv8 opcode constants, decode helper, E-stage struct   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package legv8_pkg;

  localparam logic [4:0] XZR = 5'd31;

  // Opcodes are matched on instr[31:21]; narrower formats use masks.
  localparam logic [10:0] OP_LDUR   = 11'b11111000010;
  localparam logic [10:0] OP_STUR   = 11'b11111000000;
  localparam logic [10:0] CBZ_MASK  = 11'b11111111000;
  localparam logic [10:0] CBZ_MATCH = 11'b10110100000;
  localparam logic [10:0] B_MASK    = 11'b11111100000;
  localparam logic [10:0] B_MATCH   = 11'b00010100000;
  localparam logic [10:0] R_MASK    = 11'b00011110000;
  localparam logic [10:0] R_MATCH   = 11'b00001010000;
  localparam logic [10:0] I_MASK    = 11'b00011111100;
  localparam logic [10:0] I_MATCH   = 11'b00010001000;

  typedef struct packed {
    logic        valid;
    logic        memread;
    logic        regwrite;
    logic [4:0]  wa;
    logic [31:0] instr;
  } e_ctrl_t;

  typedef struct packed {
    logic memread;
    logic regwrite;
    logic ra2_used;
  } dec_t;

  function automatic dec_t decode_op(input logic [10:0] op);
    dec_t d;
    logic is_ldur, is_stur, is_cbz, is_b, is_r, is_i;
    is_ldur    = (op == OP_LDUR);
    is_stur    = (op == OP_STUR);
    is_cbz     = ((op & CBZ_MASK) == CBZ_MATCH);
    is_b       = ((op & B_MASK) == B_MATCH);
    is_r       = ((op & R_MASK) == R_MATCH);
    is_i       = ((op & I_MASK) == I_MATCH);
    d.memread  = is_ldur;
    d.regwrite = (is_r | is_ldur | is_i) & ~is_b;
    d.ra2_used = is_r | is_stur | is_cbz;
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | hazard_unit: load-use detection and stall request                  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module hazard_unit
  import legv8_pkg::*;
(
  input  logic       valid_e,
  input  logic       memread_e,
  input  logic [4:0] wa_e,
  input  logic       valid_d,
  input  logic [4:0] ra1_d,
  input  logic [4:0] ra2_d,
  input  logic       ra2_used,
  input  logic       flush,
  input  logic       en,
  output logic       hazard,
  output logic       stall_d
);

  assign hazard  = valid_e & memread_e & (wa_e != XZR) & valid_d &
                   ((wa_e == ra1_d) | (ra2_used & (wa_e == ra2_d)));
  assign stall_d = hazard & ~flush & en;

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | id_ex_stage: LEGv8 decode->execute register with WB bypass,        |
// | load-use bubble insertion and saturating stall counter             |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module id_ex_stage
  import legv8_pkg::*;
#(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  instr_d,
  input  logic [N-1:0] pc_d,
  input  logic         valid_d,
  output logic [4:0]   ra1_d,
  output logic [4:0]   ra2_d,
  input  logic [N-1:0] rd1_d,
  input  logic [N-1:0] rd2_d,
  input  logic         we3_w,
  input  logic [4:0]   wa3_w,
  input  logic [N-1:0] wd3_w,
  input  logic         flush,
  input  logic         en,
  output logic         stall_d,
  output logic         valid_e,
  output logic [N-1:0] pc_e,
  output logic [31:0]  instr_e,
  output logic [N-1:0] rd1_e,
  output logic [N-1:0] rd2_e,
  output logic [4:0]   wa_e,
  output logic         memread_e,
  output logic         regwrite_e,
  output logic [15:0]  stall_cnt
);

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  dec_t         dec;
  logic [N-1:0] op1, op2;
  logic         hazard;

  e_ctrl_t      e_d, e_q;
  logic [N-1:0] pc_e_d, pc_e_q;
  logic [N-1:0] rd1_e_d, rd1_e_q;
  logic [N-1:0] rd2_e_d, rd2_e_q;
  logic [15:0]  stall_cnt_d, stall_cnt_q;

  // XZR reads as zero; a same-cycle writeback wins over the stale regfile read.
  function automatic logic [N-1:0] bypass(input logic [4:0] ra, input logic [N-1:0] rf,
                                          input logic we, input logic [4:0] wa,
                                          input logic [N-1:0] wd);
    if (ra == XZR) return '0;
    if (we && (wa == ra) && (wa != XZR)) return wd;
    return rf;
  endfunction

  assign dec   = decode_op(instr_d[31:21]);
  assign ra1_d = instr_d[9:5];
  assign ra2_d = instr_d[28] ? instr_d[4:0] : instr_d[20:16];
  assign op1   = bypass(ra1_d, rd1_d, we3_w, wa3_w, wd3_w);
  assign op2   = bypass(ra2_d, rd2_d, we3_w, wa3_w, wd3_w);

  hazard_unit u_hazard (
    .valid_e   (e_q.valid),
    .memread_e (e_q.memread),
    .wa_e      (e_q.wa),
    .valid_d   (valid_d),
    .ra1_d     (ra1_d),
    .ra2_d     (ra2_d),
    .ra2_used  (dec.ra2_used),
    .flush     (flush),
    .en        (en),
    .hazard    (hazard),
    .stall_d   (stall_d)
  );

  always_comb begin
    e_d         = e_q;
    pc_e_d      = pc_e_q;
    rd1_e_d     = rd1_e_q;
    rd2_e_d     = rd2_e_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      e_d.valid    = 1'b0;
      e_d.memread  = 1'b0;
      e_d.regwrite = 1'b0;
    end else if (!en) begin
      e_d = e_q;
    end else if (hazard) begin
      e_d.valid    = 1'b0;
      e_d.memread  = 1'b0;
      e_d.regwrite = 1'b0;
      if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      e_d.valid    = valid_d;
      e_d.memread  = valid_d & dec.memread;
      e_d.regwrite = valid_d & dec.regwrite;
      e_d.wa       = instr_d[4:0];
      e_d.instr    = instr_d;
      pc_e_d       = pc_d;
      rd1_e_d      = op1;
      rd2_e_d      = op2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q         <= '0;
      pc_e_q      <= '0;
      rd1_e_q     <= '0;
      rd2_e_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      e_q         <= e_d;
      pc_e_q      <= pc_e_d;
      rd1_e_q     <= rd1_e_d;
      rd2_e_q     <= rd2_e_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign valid_e    = e_q.valid;
  assign memread_e  = e_q.memread;
  assign regwrite_e = e_q.regwrite;
  assign wa_e       = e_q.wa;
  assign instr_e    = e_q.instr;
  assign pc_e       = pc_e_q;
  assign rd1_e      = rd1_e_q;
  assign rd2_e      = rd2_e_q;
  assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_id_ex_stage: directed self-checking bench for id_ex_stage       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_id_ex_stage;

  localparam logic [31:0] I_LDUR5   = {11'b11111000010, 9'd0, 2'b00, 5'd2, 5'd5};
  localparam logic [31:0] I_LDUR31  = {11'b11111000010, 9'd0, 2'b00, 5'd2, 5'd31};
  localparam logic [31:0] I_ADD6_5  = {11'b10001011000, 5'd1, 6'd0, 5'd5, 5'd6};
  localparam logic [31:0] I_ADD6_31 = {11'b10001011000, 5'd1, 6'd0, 5'd31, 5'd6};
  localparam logic [31:0] I_ADD3_2  = {11'b10001011000, 5'd4, 6'd0, 5'd2, 5'd3};
  localparam logic [31:0] I_ADD3_31 = {11'b10001011000, 5'd4, 6'd0, 5'd31, 5'd3};
  localparam logic [31:0] I_STUR7   = {11'b11111000000, 9'd0, 2'b00, 5'd1, 5'd7};
  localparam logic [31:0] I_STUR5   = {11'b11111000000, 9'd0, 2'b00, 5'd1, 5'd5};
  localparam logic [31:0] I_CBZ9    = {8'b10110100, 19'd0, 5'd9};
  localparam logic [31:0] I_ADDI5   = {10'b1001000100, 12'd5, 5'd1, 5'd5};
  localparam logic [31:0] I_B       = {6'b000101, 26'd4};

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_d;
  logic [63:0] pc_d, rd1_d, rd2_d, wd3_w;
  logic        valid_d, we3_w, flush, en;
  logic [4:0]  wa3_w;
  logic [4:0]  ra1_d, ra2_d, wa_e;
  logic        stall_d, valid_e, memread_e, regwrite_e;
  logic [63:0] pc_e, rd1_e, rd2_e;
  logic [31:0] instr_e;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.N(64)) dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .pc_d(pc_d), .valid_d(valid_d),
    .ra1_d(ra1_d), .ra2_d(ra2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .we3_w(we3_w), .wa3_w(wa3_w), .wd3_w(wd3_w), .flush(flush), .en(en),
    .stall_d(stall_d), .valid_e(valid_e), .pc_e(pc_e), .instr_e(instr_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .wa_e(wa_e), .memread_e(memread_e),
    .regwrite_e(regwrite_e), .stall_cnt(stall_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic v);
    instr_d = ins;
    pc_d    = pc;
    valid_d = v;
  endtask

  task automatic test_reset();
    #12;
    n_checks++;
    if ({valid_e, memread_e, regwrite_e, wa_e, stall_d, stall_cnt} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_hold: ctrl/cnt got %b want 0", {valid_e, memread_e, regwrite_e, wa_e, stall_d, stall_cnt});
    end
    tick();
    reset = 1'b1;
    drive(I_LDUR5, 64'd100, 1'b1);
    rd1_d = 64'd1;
    rd2_d = 64'd2;
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_cycle_stall: got %b want 0", stall_d);
    end
    tick();
    drive(I_ADD6_5, 64'd104, 1'b1);
    #1;
    n_checks++;
    if (stall_d !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_stall: got %b want 1", stall_d);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({valid_e, memread_e, regwrite_e, wa_e, stall_d, stall_cnt, pc_e, instr_e, rd1_e, rd2_e} !== '0) begin
      n_fail++;
      $display("FAIL reset_async: v=%b mr=%b rw=%b wa=%0d st=%b cnt=%0d pc=%h ins=%h rd1=%h rd2=%h want all 0",
               valid_e, memread_e, regwrite_e, wa_e, stall_d, stall_cnt, pc_e, instr_e, rd1_e, rd2_e);
    end
    tick();
    reset = 1'b1;
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drop_bubble: stall_d got %b want 0", stall_d);
    end
    tick();
    n_checks++;
    if ({valid_e, wa_e, pc_e, stall_cnt} !== {1'b1, 5'd6, 64'd104, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_after_release: v=%b wa=%0d pc=%0d cnt=%0d want 1 6 104 0", valid_e, wa_e, pc_e, stall_cnt);
    end
  endtask

  task automatic test_decode();
    drive(I_ADD3_2, 64'd0, 1'b1);
    #1;
    n_checks++;
    if ({ra1_d, ra2_d} !== {5'd2, 5'd4}) begin
      n_fail++;
      $display("FAIL decode_rtype: ra1=%0d ra2=%0d want 2 4", ra1_d, ra2_d);
    end
    drive(I_STUR7, 64'd0, 1'b1);
    #1;
    n_checks++;
    if ({ra1_d, ra2_d} !== {5'd1, 5'd7}) begin
      n_fail++;
      $display("FAIL decode_stur: ra1=%0d ra2=%0d want 1 7", ra1_d, ra2_d);
    end
    drive(I_CBZ9, 64'd0, 1'b1);
    #1;
    n_checks++;
    if ({ra1_d, ra2_d} !== {5'd0, 5'd9}) begin
      n_fail++;
      $display("FAIL decode_cbz: ra1=%0d ra2=%0d want 0 9", ra1_d, ra2_d);
    end
  endtask

  task automatic test_bypass();
    drive(I_ADD3_2, 64'd200, 1'b1);
    rd1_d = 64'h11;
    rd2_d = 64'h22;
    we3_w = 1'b1;
    wa3_w = 5'd2;
    wd3_w = 64'h55;
    tick();
    n_checks++;
    if ({rd1_e, rd2_e, pc_e, instr_e} !== {64'h55, 64'h22, 64'd200, I_ADD3_2}) begin
      n_fail++;
      $display("FAIL bypass_port1: rd1=%h rd2=%h pc=%0d ins=%h want 55 22 200 %h", rd1_e, rd2_e, pc_e, instr_e, I_ADD3_2);
    end
    n_checks++;
    if ({valid_e, memread_e, regwrite_e, wa_e} !== {3'b101, 5'd3}) begin
      n_fail++;
      $display("FAIL bypass_ctrl: v/mr/rw=%b%b%b wa=%0d want 101 3", valid_e, memread_e, regwrite_e, wa_e);
    end
    wa3_w = 5'd31;
    tick();
    n_checks++;
    if (rd1_e !== 64'h11) begin
      n_fail++;
      $display("FAIL bypass_wa31: rd1 got %h want 11", rd1_e);
    end
    wa3_w = 5'd4;
    wd3_w = 64'h77;
    tick();
    n_checks++;
    if ({rd1_e, rd2_e} !== {64'h11, 64'h77}) begin
      n_fail++;
      $display("FAIL bypass_port2: rd1=%h rd2=%h want 11 77", rd1_e, rd2_e);
    end
    we3_w = 1'b0;
    wa3_w = 5'd2;
    tick();
    n_checks++;
    if (rd1_e !== 64'h11) begin
      n_fail++;
      $display("FAIL bypass_we_off: rd1 got %h want 11", rd1_e);
    end
  endtask

  task automatic test_xzr();
    drive(I_ADD3_31, 64'd220, 1'b1);
    rd1_d = 64'hFFFF;
    we3_w = 1'b1;
    wa3_w = 5'd31;
    wd3_w = 64'h99;
    tick();
    n_checks++;
    if ({rd1_e, rd2_e} !== {64'h0, 64'h22}) begin
      n_fail++;
      $display("FAIL xzr_read: rd1=%h rd2=%h want 0 22", rd1_e, rd2_e);
    end
    we3_w = 1'b0;
  endtask

  task automatic test_control();
    logic [31:0] ins [6];
    logic        vin [6];
    logic [7:0]  exp [6];
    ins = '{I_LDUR5, I_STUR7, I_B, I_ADDI5, I_LDUR5, I_CBZ9};
    vin = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    exp = '{{3'b111, 5'd5}, {3'b100, 5'd7}, {3'b100, 5'd4},
            {3'b101, 5'd5}, {3'b000, 5'd5}, {3'b100, 5'd9}};
    for (int i = 0; i < 6; i++) begin
      drive(ins[i], 64'd240 + 64'(4 * i), vin[i]);
      tick();
      n_checks++;
      if ({valid_e, memread_e, regwrite_e, wa_e} !== exp[i]) begin
        n_fail++;
        $display("FAIL control_%0d: v/mr/rw/wa got %b want %b", i, {valid_e, memread_e, regwrite_e, wa_e}, exp[i]);
      end
    end
  endtask

  task automatic test_load_use();
    drive(I_LDUR5, 64'd300, 1'b1);
    tick();
    drive(I_ADD6_5, 64'd304, 1'b1);
    #1;
    n_checks++;
    if (stall_d !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: got %b want 1", stall_d);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++;
    if ({valid_e, memread_e, regwrite_e, stall_d, stall_cnt} !== {4'b0000, exp_cnt}) begin
      n_fail++;
      $display("FAIL lu_bubble: v/mr/rw/st=%b%b%b%b cnt=%0d want 0000 %0d", valid_e, memread_e, regwrite_e, stall_d, stall_cnt, exp_cnt);
    end
    tick();
    n_checks++;
    if ({valid_e, regwrite_e, wa_e, pc_e, stall_cnt} !== {2'b11, 5'd6, 64'd304, exp_cnt}) begin
      n_fail++;
      $display("FAIL lu_enter: v=%b rw=%b wa=%0d pc=%0d cnt=%0d want 1 1 6 304 %0d", valid_e, regwrite_e, wa_e, pc_e, stall_cnt, exp_cnt);
    end
    drive(I_LDUR5, 64'd310, 1'b1);
    tick();
    drive(I_STUR5, 64'd314, 1'b1);
    #1;
    n_checks++;
    if (stall_d !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_ra2_stall: got %b want 1", stall_d);
    end
    tick();
    exp_cnt = exp_cnt + 16'd1;
    tick();
    n_checks++;
    if ({valid_e, instr_e, stall_cnt} !== {1'b1, I_STUR5, exp_cnt}) begin
      n_fail++;
      $display("FAIL lu_ra2_enter: v=%b ins=%h cnt=%0d want 1 %h %0d", valid_e, instr_e, stall_cnt, I_STUR5, exp_cnt);
    end
    drive(I_LDUR5, 64'd320, 1'b1);
    tick();
    drive(I_ADDI5, 64'd324, 1'b1);
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_ra2_unused: stall got %b want 0", stall_d);
    end
    drive(I_LDUR31, 64'd328, 1'b1);
    tick();
    drive(I_ADD6_31, 64'd332, 1'b1);
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_xzr_dest: stall got %b want 0", stall_d);
    end
    drive(I_LDUR5, 64'd336, 1'b1);
    tick();
    drive(I_ADD6_5, 64'd340, 1'b0);
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_d_bubble: stall got %b want 0", stall_d);
    end
    tick();
  endtask

  task automatic test_flush_hazard();
    drive(I_LDUR5, 64'd400, 1'b1);
    tick();
    drive(I_ADD6_5, 64'd404, 1'b1);
    flush = 1'b1;
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stall: got %b want 0", stall_d);
    end
    tick();
    n_checks++;
    if ({valid_e, memread_e, regwrite_e, stall_cnt} !== {3'b000, exp_cnt}) begin
      n_fail++;
      $display("FAIL flush_kill: v/mr/rw=%b%b%b cnt=%0d want 000 %0d", valid_e, memread_e, regwrite_e, stall_cnt, exp_cnt);
    end
    flush = 1'b0;
    tick();
    flush = 1'b1;
    en    = 1'b0;
    tick();
    n_checks++;
    if ({valid_e, regwrite_e} !== 2'b00) begin
      n_fail++;
      $display("FAIL flush_over_en: v/rw=%b%b want 00", valid_e, regwrite_e);
    end
    flush = 1'b0;
    en    = 1'b1;
  endtask

  task automatic test_hold();
    drive(I_ADD3_2, 64'd500, 1'b1);
    rd1_d = 64'h123;
    rd2_d = 64'h456;
    tick();
    en = 1'b0;
    drive(I_LDUR5, 64'd508, 1'b1);
    rd1_d = 64'hAAA;
    rd2_d = 64'hBBB;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({valid_e, regwrite_e, wa_e, pc_e, instr_e, rd1_e, rd2_e} !== {2'b11, 5'd3, 64'd500, I_ADD3_2, 64'h123, 64'h456}) begin
        n_fail++;
        $display("FAIL hold_%0d: v=%b wa=%0d pc=%0d ins=%h rd1=%h rd2=%h want 1 3 500 %h 123 456",
                 i, valid_e, wa_e, pc_e, instr_e, rd1_e, rd2_e, I_ADD3_2);
      end
    end
    en = 1'b1;
    tick();
    drive(I_ADD6_5, 64'd512, 1'b1);
    en = 1'b0;
    #1;
    n_checks++;
    if (stall_d !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_stall_masked: got %b want 0", stall_d);
    end
    tick();
    n_checks++;
    if ({valid_e, memread_e, stall_cnt} !== {2'b11, exp_cnt}) begin
      n_fail++;
      $display("FAIL hold_hazard: v/mr=%b%b cnt=%0d want 11 %0d", valid_e, memread_e, stall_cnt, exp_cnt);
    end
    en = 1'b1;
    tick();
    exp_cnt = exp_cnt + 16'd1;
    tick();
    n_checks++;
    if ({valid_e, wa_e, stall_cnt} !== {1'b1, 5'd6, exp_cnt}) begin
      n_fail++;
      $display("FAIL hold_release: v=%b wa=%0d cnt=%0d want 1 6 %0d", valid_e, wa_e, stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] exp_sat [3];
    exp_sat = '{16'hFFFE, 16'hFFFF, 16'hFFFF};
    // Preload near the ceiling: 65535 real bubbles would take ~131k cycles.
    force dut.stall_cnt_q = 16'hFFFD;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) begin
      drive(I_LDUR5, 64'd600, 1'b1);
      tick();
      drive(I_ADD6_5, 64'd604, 1'b1);
      tick();
      n_checks++;
      if ({valid_e, stall_cnt} !== {1'b0, exp_sat[i]}) begin
        n_fail++;
        $display("FAIL saturate_%0d: v=%b cnt=%h want 0 %h", i, valid_e, stall_cnt, exp_sat[i]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    instr_d = '0;
    pc_d    = '0;
    valid_d = 1'b0;
    rd1_d   = '0;
    rd2_d   = '0;
    we3_w   = 1'b0;
    wa3_w   = '0;
    wd3_w   = '0;
    flush   = 1'b0;
    en      = 1'b1;
    exp_cnt = 16'd0;
    test_reset();
    test_decode();
    test_bypass();
    test_xzr();
    test_control();
    test_load_use();
    test_flush_hazard();
    test_hold();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
